// File: rtl/ps2_frame_receiver_pkg.sv
// rtl/ps2_frame_receiver_pkg.sv - shared types and frame constants for the PS/2 receive path
package ps2_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;
  localparam int   PS2_DATA_BITS = 8;

  // Odd parity over the data byte plus its parity bit must come out as 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// rtl/ps2_frame_receiver_if.sv - PS/2 pin inputs and received-byte outputs
interface ps2_frame_receiver_if;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;
  logic       busy;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  received_data,
    input  received_data_en,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output received_data,
    output received_data_en,
    output frame_error,
    output busy
  );

endinterface

// File: rtl/ps2_frame_receiver_line_filter.sv
// rtl/ps2_frame_receiver_line_filter.sv - 2-FF synchroniser plus debounce for the PS/2 clock line
module ps2_frame_receiver_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The idle PS/2 line is high, so the synchroniser and filtered level reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - assembles 11-bit PS/2 device-to-host frames into validated bytes
module ps2_frame_receiver #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic           CLOCK,
  input logic           reset,
  ps2_frame_receiver_if.slave bus
);

  import ps2_frame_receiver_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic       clk_level;
  logic       clk_fall;
  logic [1:0] dat_sync;
  logic       dat;
  logic       edge_seen;

  ps2_state_t    state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] tcnt;

  ps2_frame_receiver_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk   (CLOCK),
    .rst   (reset),
    .raw   (bus.PS2_CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      dat_sync <= 2'b11;
    end else begin
      dat_sync <= {dat_sync[0], bus.PS2_DAT};
    end
  end

  assign dat       = dat_sync[1];
  assign edge_seen = clk_fall & ~clk_level;

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      shift                <= '0;
      bit_cnt              <= '0;
      parity_bit           <= 1'b0;
      tcnt                 <= '0;
      bus.received_data    <= 8'h00;
      bus.received_data_en <= 1'b0;
      bus.frame_error      <= 1'b0;
      bus.busy             <= 1'b0;
    end else begin
      bus.received_data_en <= 1'b0;
      bus.frame_error      <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (edge_seen && dat == PS2_START_BIT) begin
          state    <= DATA;
          shift    <= '0;
          bit_cnt  <= '0;
          bus.busy <= 1'b1;
        end
      end else if (edge_seen) begin
        // A fall always beats a timeout landing in the same cycle.
        tcnt <= '0;
        case (state)
          DATA: begin
            shift   <= {dat, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= dat;
            state      <= STOP;
          end
          STOP: begin
            if (dat == PS2_STOP_BIT && odd_parity_ok(shift, parity_bit)) begin
              bus.received_data    <= shift;
              bus.received_data_en <= 1'b1;
            end else begin
              bus.frame_error <= 1'b1;
            end
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end else if (tcnt >= T_LAST) begin
        state           <= IDLE;
        shift           <= '0;
        bit_cnt         <= '0;
        tcnt            <= '0;
        bus.frame_error <= 1'b1;
        bus.busy        <= 1'b0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb/tb_ps2_frame_receiver.sv - randomized self-checking bench for ps2_frame_receiver
module tb_ps2_frame_receiver;

  localparam int HALF    = 40;
  localparam int TIMEOUT = 400;

  typedef struct {
    logic       is_err;
    logic [7:0] val;
    int         cyc;
  } ev_t;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t        obs[$];
  ev_t        expq[$];
  logic [7:0] last_good = 8'h00;

  ps2_frame_receiver_if bus ();

  ps2_frame_receiver #(
    .FILTER_CYCLES (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .bus  (bus)
  );

  always #10 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (!reset && (bus.received_data_en || bus.frame_error)) begin
      checks++;
      if (bus.received_data_en && bus.frame_error) begin
        errors++;
        $display("FAIL both_strobes: got en=1 err=1 at cycle %0d, want only one", cyc);
      end
      if (bus.received_data_en) obs.push_back('{1'b0, bus.received_data, cyc});
      if (bus.frame_error) obs.push_back('{1'b1, 8'h00, cyc});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Reference rule: a byte is delivered only with stop==1 and odd parity over data+parity.
  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stp);
    ev_t e;
    e.cyc = 0;
    if (stp == 1'b1 && (($countones(d) + int'(par)) % 2 == 1)) begin
      e.is_err  = 1'b0;
      e.val     = d;
      last_good = d;
    end else begin
      e.is_err = 1'b1;
      e.val    = 8'h00;
    end
    expq.push_back(e);
  endfunction

  function automatic void model_abort();
    expq.push_back('{1'b1, 8'h00, 0});
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int npulses, input int glitch_bit,
                            output int stop_cyc, output logic busy_mid);
    logic [10:0] bits;
    bits     = {stp, par, d, 1'b0};
    stop_cyc = -1;
    busy_mid = 1'b0;
    for (int i = 0; i < npulses; i++) begin
      bus.PS2_DAT = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(5);
        bus.PS2_CLK = 1'b0;
        wait_cycles(3);
        bus.PS2_CLK = 1'b1;
        wait_cycles(HALF / 2 - 8);
      end else begin
        wait_cycles(HALF / 2);
      end
      bus.PS2_CLK = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cycles(HALF);
      if (i == 0) busy_mid = bus.busy;
      bus.PS2_CLK = 1'b1;
      wait_cycles(HALF / 2);
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(5);
    checks++;
    if (bus.received_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", bus.received_data); end
    checks++;
    if (bus.received_data_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", bus.received_data_en); end
    checks++;
    if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.frame_error); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    reset = 1'b0;
    wait_cycles(20);
  endtask

  task automatic test_good_frame();
    int sc;
    logic bm;
    obs.delete(); expq.delete();
    send_frame(8'hFA, 1'b1, 1'b1, 11, -1, sc, bm);
    model_frame(8'hFA, 1'b1, 1'b1);
    wait_cycles(40);
    checks++;
    if (bm !== 1'b1) begin errors++; $display("FAIL good_busy_mid: got %0b want 1", bm); end
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL good_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL good_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
      checks++;
      if (obs[i].cyc - sc < 1 || obs[i].cyc - sc > 30) begin
        errors++; $display("FAIL good_latency: got %0d cycles want 1..30", obs[i].cyc - sc);
      end
    end
    checks++;
    if (bus.received_data !== 8'hFA) begin errors++; $display("FAIL good_data: got %02h want FA", bus.received_data); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_busy_end: got %0b want 0", bus.busy); end
  endtask

  task automatic test_parity_error();
    int sc;
    logic bm;
    obs.delete(); expq.delete();
    send_frame(8'h08, 1'b1, 1'b1, 11, -1, sc, bm);
    model_frame(8'h08, 1'b1, 1'b1);
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL parity_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err) begin
        errors++; $display("FAIL parity_ev%0d: got err=%0b want err=%0b", i, obs[i].is_err, expq[i].is_err);
      end
      checks++;
      if (obs[i].cyc - sc < 1 || obs[i].cyc - sc > 30) begin
        errors++; $display("FAIL parity_latency: got %0d cycles want 1..30", obs[i].cyc - sc);
      end
    end
    checks++;
    if (bus.received_data !== last_good) begin errors++; $display("FAIL parity_hold: got %02h want %02h", bus.received_data, last_good); end
  endtask

  task automatic test_timeout();
    int sc;
    logic bm;
    obs.delete(); expq.delete();
    send_frame(8'h3C, 1'b1, 1'b1, 5, -1, sc, bm);
    model_abort();
    wait_cycles(TIMEOUT + 100);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0b want 0", bus.busy); end
    send_frame(8'h00, 1'b1, 1'b1, 11, -1, sc, bm);
    model_frame(8'h00, 1'b1, 1'b1);
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL timeout_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL timeout_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
    end
    checks++;
    if (bus.received_data !== 8'h00) begin errors++; $display("FAIL timeout_next_data: got %02h want 00", bus.received_data); end
  endtask

  task automatic test_glitch();
    int sc;
    logic bm;
    obs.delete(); expq.delete();
    bus.PS2_CLK = 1'b0;
    wait_cycles(3);
    bus.PS2_CLK = 1'b1;
    wait_cycles(50);
    checks++;
    if (obs.size() !== 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL glitch_idle: got events=%0d busy=%0b want 0 0", obs.size(), bus.busy);
    end
    send_frame(8'h55, ~^8'h55, 1'b1, 11, 4, sc, bm);
    model_frame(8'h55, ~^8'h55, 1'b1);
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL glitch_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL glitch_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    logic bm;
    logic [7:0] pkt [3];
    pkt = '{8'h08, 8'h01, 8'hFF};
    obs.delete(); expq.delete();
    foreach (pkt[k]) begin
      send_frame(pkt[k], ~^pkt[k], 1'b1, 11, -1, sc, bm);
      model_frame(pkt[k], ~^pkt[k], 1'b1);
    end
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL b2b_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int sc;
    logic bm;
    obs.delete(); expq.delete();
    send_frame(8'hA5, ~^8'hA5, 1'b1, 6, -1, sc, bm);
    reset = 1'b1;
    wait_cycles(4);
    checks++;
    if (bus.received_data !== 8'h00 || bus.received_data_en !== 1'b0 || bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got data=%02h en=%0b err=%0b busy=%0b want 00 0 0 0",
                         bus.received_data, bus.received_data_en, bus.frame_error, bus.busy);
    end
    reset = 1'b0;
    last_good = 8'h00;
    wait_cycles(20);
    send_frame(8'h5A, ~^8'h5A, 1'b1, 11, -1, sc, bm);
    model_frame(8'h5A, ~^8'h5A, 1'b1);
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL midreset_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL midreset_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
    end
  endtask

  task automatic test_random();
    int sc;
    logic bm;
    logic [7:0] d;
    logic par, stp;
    obs.delete(); expq.delete();
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      par = (~^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 5) != 0);
      send_frame(d, par, stp, 11, -1, sc, bm);
      model_frame(d, par, stp);
    end
    wait_cycles(40);
    checks++;
    if (obs.size() !== expq.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs.size(), expq.size()); end
    else foreach (expq[i]) begin
      checks++;
      if (obs[i].is_err !== expq[i].is_err || obs[i].val !== expq[i].val) begin
        errors++; $display("FAIL rand_ev%0d: got err=%0b val=%02h want err=%0b val=%02h", i, obs[i].is_err, obs[i].val, expq[i].is_err, expq[i].val);
      end
    end
    checks++;
    if (bus.received_data !== last_good) begin errors++; $display("FAIL rand_hold: got %02h want %02h", bus.received_data, last_good); end
  endtask

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
